// File: rtl/hiscore_ram_arbiter.sv
// rtl/hiscore_ram_arbiter.sv - pauses the game CPU and lends its work-RAM port to the hiscore engine
module hiscore_ram_arbiter #(
    parameter int AW        = 10,
    parameter int SETTLE    = 4,
    parameter int RD_LAT    = 1,
    parameter int IDLE_HOLD = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] hs_addr,
    input  logic [7:0]    hs_wdata,
    input  logic          hs_write,
    input  logic          hs_access,
    output logic [7:0]    hs_rdata,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    input  logic          cpu_we,
    output logic [7:0]    cpu_rdata,
    output logic          pause_req,
    input  logic          pause_ack,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    input  logic [7:0]    ram_dout,
    output logic          hs_owned,
    output logic          wr_overflow
);
    typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_SETTLE, ST_OWN, ST_RELEASE} state_t;

    state_t          state_q;
    logic            pause_req_q, hs_owned_q;
    logic [3:0]      settle_cnt_q;
    logic [7:0]      idle_cnt_q;
    logic            buf_full_q, buf_full_d;
    logic            refill_q, refill_d;
    logic            ovf_q, ovf_d;
    logic [AW-1:0]   buf_addr_q, buf_addr_d;
    logic [7:0]      buf_data_q, buf_data_d;
    logic [RD_LAT-1:0] own_pipe_q;
    logic [7:0]      hs_rdata_q;
    logic            req;

    // A parked write keeps the request alive so it is never stranded in IDLE.
    assign req = hs_access | hs_write | buf_full_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            pause_req_q  <= 1'b0;
            hs_owned_q   <= 1'b0;
            settle_cnt_q <= '0;
            idle_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (req) begin
                    state_q     <= ST_REQ;
                    pause_req_q <= 1'b1;
                end
                ST_REQ: if (pause_ack) begin
                    state_q      <= ST_SETTLE;
                    settle_cnt_q <= '0;
                end
                ST_SETTLE: begin
                    if (!pause_ack) begin
                        state_q <= ST_REQ;
                    end else if (settle_cnt_q == 4'(SETTLE - 1)) begin
                        state_q    <= ST_OWN;
                        hs_owned_q <= 1'b1;
                        idle_cnt_q <= '0;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 4'd1;
                    end
                end
                ST_OWN: begin
                    if (req) begin
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q == 8'(IDLE_HOLD - 1)) begin
                        state_q    <= ST_RELEASE;
                        hs_owned_q <= 1'b0;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 8'd1;
                    end
                end
                ST_RELEASE: begin
                    state_q     <= ST_IDLE;
                    pause_req_q <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A write landing on the drain cycle refills the buffer once; a write on the refill's drain is lost.
    always_comb begin
        buf_full_d = buf_full_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        refill_d   = refill_q;
        ovf_d      = ovf_q;
        if (hs_owned_q) begin
            if (buf_full_q) begin
                buf_full_d = 1'b0;
                refill_d   = 1'b0;
                if (hs_write) begin
                    if (refill_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        buf_full_d = 1'b1;
                        refill_d   = 1'b1;
                        buf_addr_d = hs_addr;
                        buf_data_d = hs_wdata;
                    end
                end
            end
        end else if (hs_write) begin
            if (buf_full_q) begin
                ovf_d = 1'b1;
            end else begin
                buf_full_d = 1'b1;
                buf_addr_d = hs_addr;
                buf_data_d = hs_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_full_q <= 1'b0;
            refill_q   <= 1'b0;
            ovf_q      <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            own_pipe_q <= '0;
            hs_rdata_q <= '0;
        end else begin
            buf_full_q <= buf_full_d;
            refill_q   <= refill_d;
            ovf_q      <= ovf_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            own_pipe_q <= RD_LAT'({own_pipe_q, hs_owned_q});
            if (own_pipe_q[RD_LAT-1]) begin
                hs_rdata_q <= ram_dout;
            end
        end
    end

    always_comb begin
        if (hs_owned_q) begin
            ram_addr = buf_full_q ? buf_addr_q : hs_addr;
            ram_din  = buf_full_q ? buf_data_q : hs_wdata;
            ram_we   = buf_full_q | hs_write;
        end else begin
            ram_addr = cpu_addr;
            ram_din  = cpu_wdata;
            ram_we   = cpu_we;
        end
    end

    assign cpu_rdata   = ram_dout;
    assign hs_rdata    = hs_rdata_q;
    assign pause_req   = pause_req_q;
    assign hs_owned    = hs_owned_q;
    assign wr_overflow = ovf_q;
endmodule
